// File: rtl/beeb_bus_pkg.sv
// rtl/beeb_bus_pkg.sv - register map, reset values and FSM states for the beeb bus target
package beeb_bus_pkg;

    localparam logic [1:0] REG_SPEED  = 2'd0;
    localparam logic [1:0] REG_ROMSEL = 2'd1;
    localparam logic [1:0] REG_CNT_LO = 2'd2;
    localparam logic [1:0] REG_CNT_HI = 2'd3;

    localparam logic [5:0] SPEED_RST  = 6'd1;
    localparam logic [3:0] ROMSEL_RST = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_NS
    } state_t;

endpackage

// File: rtl/beeb_bus_target_phi_edge_sync.sv
// rtl/beeb_bus_target_phi_edge_sync.sv - Phi2 synchroniser chain plus edge flop with rise/fall detects
module phi_edge_sync #(
    parameter int NSYNC = 2
) (
    input  logic clock,
    input  logic phi2,
    output logic phi_s,
    output logic rise,
    output logic fall
);

    logic [NSYNC-1:0] sync_q;
    logic             edge_q;

    // Left unreset so a reset taken while Phi2 is high produces no spurious rise afterwards.
    always_ff @(posedge clock) begin
        sync_q <= {sync_q[NSYNC-2:0], phi2};
        edge_q <= sync_q[NSYNC-1];
    end

    assign phi_s = sync_q[NSYNC-1];
    assign rise  = phi_s & ~edge_q;
    assign fall  = ~phi_s & edge_q;

endmodule

// File: rtl/beeb_bus_target.sv
// rtl/beeb_bus_target.sv - 6502 bus responder serving the accelerator control-register window
module beeb_bus_target
    import beeb_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFE38,
    parameter int          NSYNC     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        phi2,
    input  logic [15:0] addr,
    input  logic        rnw,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [5:0]  cpu_div,
    output logic [3:0]  rom_latch,
    output logic        wr_strobe,
    output logic [1:0]  wr_index
);

    logic   phi_s, rise, fall, hit;
    state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d, widx_q, widx_d;
    logic [5:0]  speed_q, speed_d;
    logic [3:0]  rom_q, rom_d;
    logic [15:0] cnt_q, cnt_d, cnt_step;
    logic [7:0]  shadow_q, shadow_d, dout_q, dout_d;
    logic        strobe_q, strobe_d;

    phi_edge_sync #(.NSYNC(NSYNC)) u_sync (
        .clock (clock),
        .phi2  (phi2),
        .phi_s (phi_s),
        .rise  (rise),
        .fall  (fall)
    );

    assign hit = (addr[15:2] == BASE_ADDR[15:2]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        widx_d   = widx_q;
        speed_d  = speed_q;
        rom_d    = rom_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        cnt_step = rise ? cnt_q + 16'd1 : cnt_q;
        cnt_d    = cnt_step;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    idx_d = addr[1:0];
                    if (!hit) begin
                        state_d = ST_NS;
                    end else if (rnw) begin
                        state_d = ST_RD;
                        // Reads see the count including the cycle doing the read.
                        case (addr[1:0])
                            REG_SPEED:  dout_d = {2'b00, speed_q};
                            REG_ROMSEL: dout_d = {4'h0, rom_q};
                            REG_CNT_LO: begin
                                dout_d   = cnt_step[7:0];
                                shadow_d = cnt_step[15:8];
                            end
                            default:    dout_d = shadow_q;
                        endcase
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD, ST_NS: begin
                if (fall) state_d = ST_IDLE;
            end
            ST_WR: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    strobe_d = 1'b1;
                    widx_d   = idx_q;
                    case (idx_q)
                        REG_SPEED:  speed_d = (data_in[5:0] == 6'd0) ? 6'd1 : data_in[5:0];
                        REG_ROMSEL: rom_d   = data_in[3:0];
                        REG_CNT_LO: cnt_d   = 16'd0;
                        default:    ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            widx_q   <= 2'd0;
            speed_q  <= SPEED_RST;
            rom_q    <= ROMSEL_RST;
            cnt_q    <= 16'd0;
            shadow_q <= 8'd0;
            dout_q   <= 8'hFF;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            widx_q   <= widx_d;
            speed_q  <= speed_d;
            rom_q    <= rom_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
        end
    end

    assign data_out  = dout_q;
    assign data_oe   = (state_q == ST_RD);
    assign cpu_div   = speed_q - 6'd1;
    assign rom_latch = rom_q;
    assign wr_strobe = strobe_q;
    assign wr_index  = widx_q;

endmodule
